// File: rtl/result_writeback.sv
// result_writeback: captures each datapath result into the RQ/RD operand
// holding registers or a small writeback FIFO toward matrix memory. It also
// shifts quotient bits into RQ during division and keeps sign/zero flags of
// the last accepted result for the sequencer.
module result_writeback #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  input  logic [W-1:0]               res_data,
  input  logic [1:0]                 res_dst,
  output logic                       res_ready,
  input  logic                       clr_q,
  input  logic                       clr_d,
  input  logic                       q_shift,
  input  logic                       q_bit,
  output logic [W-1:0]               RQ,
  output logic [W-1:0]               RD,
  output logic                       wb_valid,
  output logic [W-1:0]               wb_data,
  input  logic                       wb_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       flag_neg,
  output logic                       flag_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] DST_RQ   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_FIFO = 2'b10;

  logic [W-1:0]  r_rq;
  logic [W-1:0]  r_rd;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_flagNeg;
  logic          r_flagZero;

  logic w_acc;
  logic w_push;
  logic w_pop;
  logic w_full;

  // Ready only drops for a memory-bound result while the FIFO is full; it
  // deliberately ignores wb_ready so a same-cycle pop never frees a full slot.
  assign w_full    = (r_count == CW'(DEPTH));
  assign res_ready = !((res_dst == DST_FIFO) && w_full);
  assign w_acc     = res_valid && res_ready;
  assign w_push    = w_acc && (res_dst == DST_FIFO);
  assign w_pop     = (r_count != '0) && wb_ready;

  assign RQ         = r_rq;
  assign RD         = r_rd;
  assign wb_valid   = (r_count != '0);
  assign wb_data    = r_mem[r_rdPtr];
  assign fifo_count = r_count;
  assign flag_neg   = r_flagNeg;
  assign flag_zero  = r_flagZero;

  // RQ: clear beats a direct write, which beats a quotient shift step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rq <= '0;
    end else if (clr_q) begin
      r_rq <= '0;
    end else if (w_acc && (res_dst == DST_RQ)) begin
      r_rq <= res_data;
    end else if (q_shift) begin
      r_rq <= {r_rq[W-2:0], q_bit};
    end
  end

  // RD: clear beats a direct write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
    end else if (clr_d) begin
      r_rd <= '0;
    end else if (w_acc && (res_dst == DST_RD)) begin
      r_rd <= res_data;
    end
  end

  // FIFO storage is left unreset; entries are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= res_data;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Flags track every accepted result, including discard-destination ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flagNeg  <= 1'b0;
      r_flagZero <= 1'b1;
    end else if (w_acc) begin
      r_flagNeg  <= res_data[W-1];
      r_flagZero <= (res_data == '0);
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed vector table for the register/flag paths
// plus hand-written sequences for FIFO fill, streaming wrap and mid-run reset.
module tb_result_writeback;

  localparam int W     = 24;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [1:0]    res_dst;
  logic          res_ready;
  logic          clr_q;
  logic          clr_d;
  logic          q_shift;
  logic          q_bit;
  logic [W-1:0]  RQ;
  logic [W-1:0]  RD;
  logic          wb_valid;
  logic [W-1:0]  wb_data;
  logic          wb_ready;
  logic [2:0]    fifo_count;
  logic          flag_neg;
  logic          flag_zero;

  int checks   = 0;
  int failures = 0;

  result_writeback #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_dst    (res_dst),
    .res_ready  (res_ready),
    .clr_q      (clr_q),
    .clr_d      (clr_d),
    .q_shift    (q_shift),
    .q_bit      (q_bit),
    .RQ         (RQ),
    .RD         (RD),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .fifo_count (fifo_count),
    .flag_neg   (flag_neg),
    .flag_zero  (flag_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          valid;
    logic [W-1:0]  data;
    logic [1:0]    dst;
    logic          clrQ;
    logic          clrD;
    logic          qShift;
    logic          qBit;
    logic          expReady;
    logic [W-1:0]  expRq;
    logic [W-1:0]  expRd;
    logic          expNeg;
    logic          expZero;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    rst       = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_dst   = 2'b11;
    clr_q     = 1'b0;
    clr_d     = 1'b0;
    q_shift   = 1'b0;
    q_bit     = 1'b0;
  endtask

  // Drive one vector at the falling edge, check ready before and registers after the rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rst       = v.rst;
    res_valid = v.valid;
    res_data  = v.data;
    res_dst   = v.dst;
    clr_q     = v.clrQ;
    clr_d     = v.clrD;
    q_shift   = v.qShift;
    q_bit     = v.qBit;
    #1;
    checkOutput($sformatf("vec%0d res_ready", idx), {31'd0, res_ready}, {31'd0, v.expReady});
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d RQ", idx), {8'd0, RQ}, {8'd0, v.expRq});
    checkOutput($sformatf("vec%0d RD", idx), {8'd0, RD}, {8'd0, v.expRd});
    checkOutput($sformatf("vec%0d flag_neg", idx), {31'd0, flag_neg}, {31'd0, v.expNeg});
    checkOutput($sformatf("vec%0d flag_zero", idx), {31'd0, flag_zero}, {31'd0, v.expZero});
    checkOutput($sformatf("vec%0d fifo_count", idx), {29'd0, fifo_count}, 32'd0);
  endtask

  // Present a result at the falling edge and let it be clocked in.
  task automatic driveResult(input logic [W-1:0] data, input logic [1:0] dst, input logic expReady, input string name);
    @(negedge clk);
    idleInputs();
    res_valid = 1'b1;
    res_data  = data;
    res_dst   = dst;
    #1;
    checkOutput(name, {31'd0, res_ready}, {31'd0, expReady});
    @(posedge clk);
  endtask

  initial begin
    //            rst  vld  data         dst    clrQ clrD qSh  qB   rdy  RQ           RD           neg  zero
    vecs[0]  = '{1'b1, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000, 24'h000000, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 24'h123456, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 24'h000000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 24'hABCDEF, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 24'hABCDEF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 24'h000000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 24'hABCDEF, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 24'h000001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000001, 24'hABCDEF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 24'h0FF00D, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 24'hABCDEF, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 24'h0FF00D, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h0FF00D, 24'hABCDEF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 24'h000000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h1FE01B, 24'hABCDEF, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 24'h000000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h1FE01B, 24'h000000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 24'hFFFFFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h1FE01B, 24'h000000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 24'hFFFFFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h1FE01B, 24'h000000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 24'h000000, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, 24'h000000, 1'b1, 1'b0};

    idleInputs();
    wb_ready = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
    end
    checkOutput("reset-path wb_valid", {31'd0, wb_valid}, 32'd0);

    // Fill with wb_ready low: four accepted, fifth refused.
    for (int k = 1; k <= 5; k++) begin
      driveResult(24'(k), 2'b10, (k <= 4) ? 1'b1 : 1'b0, $sformatf("fill%0d res_ready", k));
      #1;
      checkOutput($sformatf("fill%0d fifo_count", k), {29'd0, fifo_count}, (k <= 4) ? k : 4);
      checkOutput($sformatf("fill%0d wb_data", k), {8'd0, wb_data}, 32'd1);
    end

    // Full FIFO with a pop offered: push must still be blocked.
    @(negedge clk);
    idleInputs();
    res_valid = 1'b1;
    res_data  = 24'h0000AA;
    res_dst   = 2'b10;
    wb_ready  = 1'b1;
    #1;
    checkOutput("full+pop res_ready", {31'd0, res_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("full+pop fifo_count", {29'd0, fifo_count}, 32'd3);

    // Drain remaining words in order.
    @(negedge clk);
    idleInputs();
    for (int k = 2; k <= 4; k++) begin
      #1;
      checkOutput($sformatf("drain%0d wb_valid", k), {31'd0, wb_valid}, 32'd1);
      checkOutput($sformatf("drain%0d wb_data", k), {8'd0, wb_data}, 32'(k));
      @(negedge clk);
    end
    checkOutput("drained wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("drained fifo_count", {29'd0, fifo_count}, 32'd0);

    // Continuous push/pop stream that wraps the pointers several times.
    for (int k = 1; k <= 10; k++) begin
      res_valid = 1'b1;
      res_data  = 24'(k);
      res_dst   = 2'b10;
      #1;
      checkOutput($sformatf("stream%0d res_ready", k), {31'd0, res_ready}, 32'd1);
      if (k > 1) begin
        checkOutput($sformatf("stream%0d fifo_count", k), {29'd0, fifo_count}, 32'd1);
        checkOutput($sformatf("stream%0d wb_data", k), {8'd0, wb_data}, 32'(k - 1));
      end
      @(negedge clk);
    end
    idleInputs();
    #1;
    checkOutput("stream tail wb_data", {8'd0, wb_data}, 32'd10);
    checkOutput("stream tail fifo_count", {29'd0, fifo_count}, 32'd1);
    @(negedge clk);
    checkOutput("stream end wb_valid", {31'd0, wb_valid}, 32'd0);

    // Mid-run reset discards queued words and RQ.
    wb_ready = 1'b0;
    driveResult(24'h000011, 2'b10, 1'b1, "mid q1 res_ready");
    driveResult(24'h000022, 2'b10, 1'b1, "mid q2 res_ready");
    driveResult(24'h000033, 2'b10, 1'b1, "mid q3 res_ready");
    driveResult(24'hC0FFEE, 2'b00, 1'b1, "mid rq res_ready");
    #1;
    checkOutput("mid pre-reset RQ", {8'd0, RQ}, 32'h00C0FFEE);
    checkOutput("mid pre-reset fifo_count", {29'd0, fifo_count}, 32'd3);
    @(negedge clk);
    idleInputs();
    rst       = 1'b1;
    res_valid = 1'b1;
    res_data  = 24'h800000;
    res_dst   = 2'b10;
    @(posedge clk);
    #1;
    checkOutput("post-reset fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("post-reset wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("post-reset RQ", {8'd0, RQ}, 32'd0);
    checkOutput("post-reset flag_zero", {31'd0, flag_zero}, 32'd1);
    checkOutput("post-reset flag_neg", {31'd0, flag_neg}, 32'd0);

    // First word after reset must come out from the reset pointer position.
    driveResult(24'h000077, 2'b10, 1'b1, "after-reset push res_ready");
    #1;
    checkOutput("after-reset fifo_count", {29'd0, fifo_count}, 32'd1);
    checkOutput("after-reset wb_data", {8'd0, wb_data}, 32'h00000077);

    @(negedge clk);
    idleInputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
# result_writeback

Writeback end of the datapath operand path: accepts the W-bit result of each datapath operation and routes it back into the RQ and RD holding registers that feed the operand router, or queues it in a small FIFO for writeback to matrix memory. Also builds quotient bits into RQ for shift-subtract division, and keeps sign/zero flags of the last accepted result for the sequencer. Sits between the adder/shifter output and the operand router inputs (RQ, RD) and the memory write port.

## Interface
Parameters:
- W, 24, datapath word width (two's complement).
- DEPTH, 4, writeback FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous, active-high.
- res_valid  in  1  result present on res_data this cycle.
- res_data  in  W  datapath result.
- res_dst  in  2  destination: 00 RQ, 01 RD, 10 memory FIFO, 11 discard (flags only).
- res_ready  out  1  result accepted when res_valid & res_ready.
- clr_q  in  1  clear RQ to 0.
- clr_d  in  1  clear RD to 0.
- q_shift  in  1  quotient step: RQ <= {RQ[W-2:0], q_bit}.
- q_bit  in  1  quotient bit shifted in by q_shift.
- RQ  out  W  quotient/accumulator register, drives operand router RQ.
- RD  out  W  divisor/data register, drives operand router RD.
- wb_valid  out  1  FIFO head valid.
- wb_data  out  W  FIFO head word.
- wb_ready  in  1  memory side takes head when wb_valid & wb_ready.
- fifo_count  out  clog2(DEPTH)+1  entries held.
- flag_neg  out  1  MSB of last accepted result.
- flag_zero  out  1  last accepted result == 0.

## Operation
- Accept: acc = res_valid & res_ready. res_ready = 0 only when res_dst == 10 and FIFO full (count == DEPTH); otherwise 1. res_ready depends only on res_dst and registered count, never on wb_ready.
- RQ next-state priority (highest first): rst -> 0; clr_q -> 0; acc & res_dst==00 -> res_data; q_shift -> {RQ[W-2:0], q_bit}; else hold.
- RD next-state: rst -> 0; clr_d -> 0; acc & res_dst==01 -> res_data; else hold.
- FIFO: push on acc & res_dst==10; pop on wb_valid & wb_ready. Circular buffer, read/write pointers wrap modulo DEPTH. wb_valid = (count != 0); wb_data = entry at read pointer (registered storage, no bypass from res_data).
- Simultaneous push and pop: count unchanged, both pointers advance; legal at any count 1..DEPTH-1. At count == DEPTH push is blocked (ready low) even if a pop occurs that cycle. At count == 0 pop cannot occur (wb_valid low).
- Flags: on every acc (any res_dst, including 11) flag_neg <= res_data[W-1], flag_zero <= (res_data == 0). Held otherwise. clr_q/clr_d/q_shift do not affect flags.
- Result with res_dst == 11: accepted, only flags update.
- res_data not interpreted arithmetically; no width conversion.

## Timing
- Reset values: RQ = 0, RD = 0, wb_valid = 0, fifo_count = 0, pointers = 0, flag_neg = 0, flag_zero = 1. wb_data don't-care while wb_valid = 0. res_ready = 1 after reset.
- Reset mid-operation: FIFO contents discarded, all outputs return to reset values the cycle after rst sampled high; inputs ignored that cycle.
- Latency: accepted result appears on RQ/RD, flags, and (if FIFO was empty) wb_data/wb_valid one cycle after acceptance edge.
- Throughput: one result per cycle; sustained full-rate FIFO flow with wb_ready held high.
- Pop effect visible next cycle (count decrements, next head shown).
- No combinational path from res_* to wb_* or RQ/RD outputs.

## Test plan
- Reset: drive rst 1 cycle -> RQ=0, RD=0, wb_valid=0, fifo_count=0, flag_zero=1, flag_neg=0, res_ready=1.
- Register writes: res_data=24'h123456 dst 00, then 24'hABCDEF dst 01 -> RQ=123456, RD=ABCDEF; after second, flag_neg=1, flag_zero=0; then 24'h000000 dst 11 -> RQ/RD unchanged, flag_zero=1.
- Priority: RQ=000001, same cycle clr_q=1, res dst 00 = 24'h0FF00D, q_shift=1 -> RQ=0; next cycle res dst 00 = 0FF00D with q_shift=1 q_bit=1 -> RQ=0FF00D; then q_shift q_bit=1 alone -> RQ=1FE01B.
- FIFO fill/drain: wb_ready=0, push 5 words 1..5 dst 10 -> first 4 accepted, res_ready low on 5th, fifo_count=4; raise wb_ready -> wb_data sequence 1,2,3,4 one per cycle, then wb_valid=0.
- Simultaneous push/pop with wrap: wb_ready=1, stream 10 words dst 10 continuously -> fifo_count stays 1 after first, output order 1..10, pointers wrap without loss.
- Reset mid-stream: 3 words queued, RQ=C0FFEE, assert rst -> next cycle fifo_count=0, wb_valid=0, RQ=0.
